// File: rtl/mic_volume_meter_if.sv
// mic_volume_meter_if
// Groups the microphone sample path and the loudness results of the volume
// meter into one bundle.
//   enable_mic   : measurement enable (driver -> meter)
//   mic_in[11:0] : unsigned mic sample, valid every clock (driver -> meter)
//   volume[3:0]  : smoothed loudness 0..15 (meter -> game)
//   volume_valid : one-cycle pulse when volume is updated (meter -> game)
//   peak_raw     : peak of the last completed window (meter -> game)
//   led_bar      : thermometer display of volume (meter -> game)
// Modports: master = sample source / result consumer, slave = the meter.
interface mic_volume_meter_if;
  logic        enable_mic;
  logic [11:0] mic_in;
  logic [3:0]  volume;
  logic        volume_valid;
  logic [11:0] peak_raw;
  logic [15:0] led_bar;

  modport master (
    output enable_mic, mic_in,
    input  volume, volume_valid, peak_raw, led_bar
  );

  modport slave (
    input  enable_mic, mic_in,
    output volume, volume_valid, peak_raw, led_bar
  );
endinterface

// File: rtl/mic_volume_meter.sv
// mic_volume_meter
// Measures microphone loudness by tracking the peak sample over fixed windows
// of WINDOW samples, converting the peak to a 0..15 level and smoothing it
// with fast attack / slow release.
//   clock_20khz  : sole clock, one mic sample per rising edge
//   game_reset_n : asynchronous active-low reset
//   bus          : mic_volume_meter_if slave (enable_mic, mic_in in;
//                  volume, volume_valid, peak_raw, led_bar out)
module mic_volume_meter #(
  parameter int WINDOW      = 4000,
  parameter int MIDPOINT    = 2048,
  parameter int NOISE_FLOOR = 2176,
  parameter int SHIFT       = 7
) (
  input logic                 clock_20khz,
  input logic                 game_reset_n,
  mic_volume_meter_if.slave   bus
);

  localparam int CW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [CW-1:0] LAST  = CW'(WINDOW - 1);
  localparam logic [12:0]   MID13 = 13'(MIDPOINT);
  localparam logic [12:0]   NF13  = 13'(NOISE_FLOOR);

  logic [CW-1:0] wcnt;
  logic [11:0]   pk;
  logic [11:0]   peak_q;
  logic [3:0]    vol_q;
  logic          valid_q;

  logic [11:0]   p;
  logic [12:0]   p13;
  logic [12:0]   above_mid;
  logic [12:0]   scaled;
  logic [3:0]    level;
  logic [3:0]    vol_next;
  logic [16:0]   therm;

  // Peak including the current sample, so the closing sample of a window counts.
  always_comb begin
    p = (bus.mic_in > pk) ? bus.mic_in : pk;
  end

  // 13-bit arithmetic keeps full-scale input from wrapping.
  always_comb begin
    p13       = {1'b0, p};
    above_mid = p13 - MID13;
    scaled    = above_mid >> SHIFT;
    level     = 4'd0;
    if (p13 >= NF13 && p13 > MID13) begin
      level = (scaled > 13'd15) ? 4'd15 : scaled[3:0];
    end
  end

  // Fast attack, slow release. level < vol_q implies vol_q >= 1, so no underflow.
  always_comb begin
    vol_next = (level >= vol_q) ? level : (vol_q - 4'd1);
  end

  always_ff @(posedge clock_20khz or negedge game_reset_n) begin
    if (!game_reset_n) begin
      wcnt    <= '0;
      pk      <= '0;
      peak_q  <= '0;
      vol_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (!bus.enable_mic) begin
        // Window progress is frozen, only the displayed volume is dropped.
        vol_q <= '0;
      end else if (wcnt == LAST) begin
        peak_q  <= p;
        pk      <= '0;
        wcnt    <= '0;
        vol_q   <= vol_next;
        valid_q <= 1'b1;
      end else begin
        pk   <= p;
        wcnt <= wcnt + 1'b1;
      end
    end
  end

  // Thermometer: lowest vol_q bits set.
  always_comb begin
    therm = (17'd1 << vol_q) - 17'd1;
  end

  assign bus.volume       = vol_q;
  assign bus.volume_valid = valid_q;
  assign bus.peak_raw     = peak_q;
  assign bus.led_bar      = therm[15:0];

endmodule

// File: tb/tb_mic_volume_meter.sv
// tb_mic_volume_meter
// Directed bench for mic_volume_meter with WINDOW=8 and default levels.
module tb_mic_volume_meter;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  mic_volume_meter_if bus ();

  mic_volume_meter #(
    .WINDOW      (8),
    .MIDPOINT    (2048),
    .NOISE_FLOOR (2176),
    .SHIFT       (7)
  ) dut (
    .clock_20khz  (clk),
    .game_reset_n (rst_n),
    .bus          (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full window of 8 samples: silence except sample 'pos' = 'loud'.
  // 'early' counts pulses seen before the closing edge.
  task automatic run_window(input logic [11:0] loud, input int pos, output int early);
    early = 0;
    for (int i = 0; i < 8; i++) begin
      bus.mic_in = (i == pos) ? loud : 12'd2048;
      tick();
      if (i < 7 && bus.volume_valid === 1'b1) early++;
    end
    bus.mic_in = 12'd2048;
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    bus.enable_mic = 1'b1;
    bus.mic_in     = 12'd2048;
    #3;
    checks++;
    if (bus.volume !== 4'd0 || bus.volume_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_vol: volume=%0d valid=%0b, want 0/0", bus.volume, bus.volume_valid);
    end
    checks++;
    if (bus.peak_raw !== 12'd0 || bus.led_bar !== 16'h0000) begin
      errors++;
      $display("FAIL reset_peak_led: peak=%0d led=%h, want 0/0000", bus.peak_raw, bus.led_bar);
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_silence();
    int early;
    for (int w = 0; w < 2; w++) begin
      run_window(12'd2048, 0, early);
      checks++;
      if (early !== 0 || bus.volume_valid !== 1'b1) begin
        errors++;
        $display("FAIL silence_pulse w%0d: early=%0d valid=%0b, want 0/1", w, early, bus.volume_valid);
      end
      checks++;
      if (bus.peak_raw !== 12'd2048 || bus.volume !== 4'd0 || bus.led_bar !== 16'h0000) begin
        errors++;
        $display("FAIL silence_out w%0d: peak=%0d vol=%0d led=%h, want 2048/0/0000",
                 w, bus.peak_raw, bus.volume, bus.led_bar);
      end
    end
  endtask

  task automatic test_attack();
    int early;
    // Loud sample on the closing edge itself.
    run_window(12'd2688, 7, early);
    checks++;
    if (early !== 0 || bus.volume_valid !== 1'b1) begin
      errors++;
      $display("FAIL attack_pulse: early=%0d valid=%0b, want 0/1", early, bus.volume_valid);
    end
    checks++;
    if (bus.volume !== 4'd5 || bus.led_bar !== 16'h001F || bus.peak_raw !== 12'd2688) begin
      errors++;
      $display("FAIL attack_out: vol=%0d led=%h peak=%0d, want 5/001F/2688",
               bus.volume, bus.led_bar, bus.peak_raw);
    end
  endtask

  task automatic test_release();
    int early;
    logic [3:0]  exp_vol;
    logic [15:0] exp_led;
    logic [15:0] led_tab [0:5];
    led_tab[0] = 16'h000F; led_tab[1] = 16'h0007; led_tab[2] = 16'h0003;
    led_tab[3] = 16'h0001; led_tab[4] = 16'h0000; led_tab[5] = 16'h0000;
    for (int k = 0; k < 6; k++) begin
      exp_vol = (k < 4) ? 4'(4 - k) : 4'd0;
      exp_led = led_tab[k];
      run_window(12'd2048, 0, early);
      checks++;
      if (bus.volume !== exp_vol || bus.led_bar !== exp_led || bus.peak_raw !== 12'd2048
          || bus.volume_valid !== 1'b1 || early !== 0) begin
        errors++;
        $display("FAIL release_%0d: vol=%0d led=%h peak=%0d valid=%0b early=%0d, want %0d/%h/2048/1/0",
                 k, bus.volume, bus.led_bar, bus.peak_raw, bus.volume_valid, early, exp_vol, exp_led);
      end
    end
    // Pulse lasts exactly one cycle.
    bus.mic_in = 12'd2048;
    tick();
    checks++;
    if (bus.volume_valid !== 1'b0) begin
      errors++;
      $display("FAIL pulse_width: valid=%0b, want 0", bus.volume_valid);
    end
    // Finish that window so later tests start aligned.
    for (int i = 0; i < 7; i++) tick();
  endtask

  task automatic test_levels();
    int early;
    logic [11:0] pk_tab  [0:4];
    logic [3:0]  vol_tab [0:4];
    logic [15:0] led_tab [0:4];
    pk_tab[0] = 12'd2150; vol_tab[0] = 4'd0;  led_tab[0] = 16'h0000;
    pk_tab[1] = 12'd2175; vol_tab[1] = 4'd0;  led_tab[1] = 16'h0000;
    pk_tab[2] = 12'd2176; vol_tab[2] = 4'd1;  led_tab[2] = 16'h0001;
    pk_tab[3] = 12'd4095; vol_tab[3] = 4'd15; led_tab[3] = 16'h7FFF;
    pk_tab[4] = 12'd2688; vol_tab[4] = 4'd14; led_tab[4] = 16'h3FFF;
    for (int k = 0; k < 5; k++) begin
      run_window(pk_tab[k], k, early);
      checks++;
      if (bus.volume !== vol_tab[k] || bus.led_bar !== led_tab[k] || bus.peak_raw !== pk_tab[k]
          || bus.volume_valid !== 1'b1) begin
        errors++;
        $display("FAIL level_%0d: vol=%0d led=%h peak=%0d valid=%0b, want %0d/%h/%0d/1",
                 k, bus.volume, bus.led_bar, bus.peak_raw, bus.volume_valid,
                 vol_tab[k], led_tab[k], pk_tab[k]);
      end
    end
  endtask

  task automatic test_reset_mid_window();
    int early;
    for (int i = 0; i < 5; i++) begin
      bus.mic_in = 12'd4000;
      tick();
    end
    bus.mic_in = 12'd4095;
    rst_n = 1'b0;
    #2;
    checks++;
    if (bus.volume !== 4'd0 || bus.volume_valid !== 1'b0 || bus.peak_raw !== 12'd0
        || bus.led_bar !== 16'h0000) begin
      errors++;
      $display("FAIL async_reset: vol=%0d valid=%0b peak=%0d led=%h, want all 0",
               bus.volume, bus.volume_valid, bus.peak_raw, bus.led_bar);
    end
    tick();
    rst_n = 1'b1;
    run_window(12'd2048, 0, early);
    checks++;
    if (early !== 0 || bus.volume_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_full_window: early=%0d valid=%0b, want 0/1", early, bus.volume_valid);
    end
    checks++;
    if (bus.volume !== 4'd0 || bus.peak_raw !== 12'd2048) begin
      errors++;
      $display("FAIL reset_discard: vol=%0d peak=%0d, want 0/2048", bus.volume, bus.peak_raw);
    end
  endtask

  task automatic test_enable_toggle();
    int early;
    int pulses;
    run_window(12'd2688, 2, early);
    checks++;
    if (bus.volume !== 4'd5) begin
      errors++;
      $display("FAIL en_pre_vol: vol=%0d, want 5", bus.volume);
    end
    bus.mic_in = 12'd2048; tick();
    bus.mic_in = 12'd3200; tick();
    bus.mic_in = 12'd2048; tick();
    bus.enable_mic = 1'b0;
    bus.mic_in     = 12'd4095;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.volume_valid === 1'b1) pulses++;
      if (i == 0) begin
        checks++;
        if (bus.volume !== 4'd0 || bus.led_bar !== 16'h0000) begin
          errors++;
          $display("FAIL en_off_vol: vol=%0d led=%h, want 0/0000", bus.volume, bus.led_bar);
        end
      end
    end
    checks++;
    if (pulses !== 0 || bus.peak_raw !== 12'd2688) begin
      errors++;
      $display("FAIL en_off_hold: pulses=%0d peak=%0d, want 0/2688", pulses, bus.peak_raw);
    end
    bus.enable_mic = 1'b1;
    bus.mic_in     = 12'd2048;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.volume_valid === 1'b1) pulses++;
    end
    tick();
    checks++;
    if (pulses !== 0 || bus.volume_valid !== 1'b1) begin
      errors++;
      $display("FAIL en_resume_pulse: early=%0d valid=%0b, want 0/1", pulses, bus.volume_valid);
    end
    checks++;
    if (bus.peak_raw !== 12'd3200 || bus.volume !== 4'd9 || bus.led_bar !== 16'h01FF) begin
      errors++;
      $display("FAIL en_resume_out: peak=%0d vol=%0d led=%h, want 3200/9/01FF",
               bus.peak_raw, bus.volume, bus.led_bar);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_silence();
    test_attack();
    test_release();
    test_levels();
    test_reset_mid_window();
    test_enable_toggle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
